// File: rtl/seq_divider_pkg.sv
// Shared arithmetic definitions for the sequential divider: default widths,
// FSM state encoding and the iteration count.
package seq_divider_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int ITER       = DIVIDEND_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: compare the shifted partial remainder against
// the divisor and subtract when it fits (9-bit unsigned arithmetic).
module div_step
  import seq_divider_pkg::*;
#(
  parameter int DW = seq_divider_pkg::DIVISOR_W
) (
  input  logic [DW:0]   pr_shift_i,
  input  logic [DW-1:0] divisor_i,
  output logic [DW:0]   pr_next_o,
  output logic          q_bit_o
);

  logic [DW:0] divisor_ext;

  assign divisor_ext = {1'b0, divisor_i};

  always_comb begin
    pr_next_o = pr_shift_i;
    q_bit_o   = 1'b0;
    if (pr_shift_i >= divisor_ext) begin
      pr_next_o = pr_shift_i - divisor_ext;
      q_bit_o   = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle, with a start/busy/done
// handshake. quotient/remainder are the working registers themselves.
module seq_divider #(
  parameter int DIVIDEND_W = seq_divider_pkg::DIVIDEND_W,
  parameter int DIVISOR_W  = seq_divider_pkg::DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic [1:0]            dbg_state
);

  import seq_divider_pkg::*;

  localparam int CNT_W = $clog2(DIVIDEND_W);

  // Handshake: start is honoured only when busy=0 (IDLE or FIN); a start seen
  // during RUN is dropped, not queued. done pulses for exactly the FIN cycle.

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] q_q, q_d;
  logic [DIVISOR_W:0]    pr_q, pr_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W:0]    pr_shift;
  logic [DIVISOR_W:0]    pr_next;
  logic                  q_bit;

  assign pr_shift = {pr_q[DIVISOR_W-1:0], q_q[DIVIDEND_W-1]};

  div_step #(.DW(DIVISOR_W)) u_step (
    .pr_shift_i (pr_shift),
    .divisor_i  (dvs_q),
    .pr_next_o  (pr_next),
    .q_bit_o    (q_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    pr_d    = pr_q;
    dvs_d   = dvs_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          q_d     = dividend;
          pr_d    = '0;
          dvs_d   = divisor;
          cnt_d   = CNT_W'(DIVIDEND_W - 1);
          dbz_d   = 1'b0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // A zero divisor skips the iterations; the dividend low byte is still
        // sitting untouched in the quotient register.
        if (dvs_q == '0) begin
          q_d     = '1;
          pr_d    = {1'b0, q_q[DIVISOR_W-1:0]};
          dbz_d   = 1'b1;
          cnt_d   = '0;
          state_d = FIN;
        end else begin
          q_d   = {q_q[DIVIDEND_W-2:0], q_bit};
          pr_d  = pr_next;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = FIN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      pr_q    <= '0;
      dvs_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      pr_q    <= pr_d;
      dvs_q   <= dvs_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == FIN);
  assign quotient    = q_q;
  assign remainder   = pr_q[DIVISOR_W-1:0];
  assign div_by_zero = dbz_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider against plain integer
// division computed in the bench.
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  seq_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver: present one start for one edge, return #1 after the accepting edge
  task automatic apply_start(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // counts edges until done is seen; -1 if the bound expires
  task automatic wait_done(output int lat);
    lat = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) return;
    end
    lat = -1;
  endtask

  task automatic check_result(input string tag, input logic [15:0] a, input logic [7:0] b,
                              input int lat);
    int exp_q, exp_r, exp_lat;
    if (b == 0) begin
      exp_q = 16'hFFFF; exp_r = int'(a[7:0]); exp_lat = 1;
    end else begin
      exp_q = int'(a) / int'(b); exp_r = int'(a) % int'(b); exp_lat = 16;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_q"}, quotient, exp_q);
    chk({tag, "_r"}, remainder, exp_r);
    chk({tag, "_dbz"}, div_by_zero, (b == 0) ? 1 : 0);
  endtask

  initial begin
    int lat;
    logic [15:0] a;
    logic [7:0]  b;

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 200 / 7 with done pulse width
    apply_start(16'd200, 8'd7);
    chk("acc_busy", busy, 1);
    wait_done(lat);
    check_result("d200_7", 16'd200, 8'd7, lat);
    chk("fin_busy", busy, 0);
    @(posedge clk); #1;
    chk("done_width", done, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_q", quotient, 28);
    chk("hold_r", remainder, 4);

    apply_start(16'hFFFF, 8'd1);   wait_done(lat); check_result("ffff_1", 16'hFFFF, 8'd1, lat);
    apply_start(16'hFFFF, 8'hFF);  wait_done(lat); check_result("ffff_ff", 16'hFFFF, 8'hFF, lat);
    chk("ffff_ff_q257", quotient, 257);
    apply_start(16'h1234, 8'd0);   wait_done(lat); check_result("div0", 16'h1234, 8'd0, lat);
    @(posedge clk); #1;
    chk("div0_hold_dbz", div_by_zero, 1);

    // start while busy is dropped
    apply_start(16'd1000, 8'd9);
    repeat (5) @(posedge clk);
    apply_start(16'd100, 8'd3);
    wait_done(lat);
    chk("ign_lat", lat, 10);
    chk("ign_q", quotient, 111);
    chk("ign_r", remainder, 1);

    // accept in the FIN cycle
    apply_start(16'd1000, 8'd9);
    wait_done(lat);
    chk("b2b_first_lat", lat, 16);
    chk("b2b_first_done", done, 1);
    apply_start(16'd100, 8'd3);
    chk("b2b_busy", busy, 1);
    chk("b2b_done_low", done, 0);
    chk("b2b_dbz_clr", div_by_zero, 0);
    wait_done(lat);
    check_result("b2b_100_3", 16'd100, 8'd3, lat);

    // reset at iteration 8
    apply_start(16'd1000, 8'd9);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_q", quotient, 0);
    chk("mid_rst_r", remainder, 0);
    chk("mid_rst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_no_done", done, 0);
    apply_start(16'd50, 8'd5); wait_done(lat); check_result("d50_5", 16'd50, 8'd5, lat);

    // random sweep against integer division
    for (int i = 0; i < 2000; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 8'($urandom_range(1, 255));
      apply_start(a, b);
      wait_done(lat);
      check_result("rand", a, b, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
